// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared widths, destination field and FSM encoding for the FIFO round-robin arbiter.
package fifo_rr_arbiter_pkg;

  localparam int unsigned DATA_W    = 6;
  localparam int unsigned DEST_MSB  = 5;
  localparam int unsigned DEST_LSB  = 4;
  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// Four-way round-robin priority search: first requester at or above rr_i, wrapping 3->0.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] rr_i,
  output logic [3:0] gnt_o,
  output logic       valid_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = rr_i;
    for (int i = 0; i < 4; i++) begin
      idx = rr_i + 2'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Pops non-empty input FIFOs in round-robin order and routes each word to the output FIFO
// selected by its top two bits, with a fixed two-cycle pop-to-push pipeline.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN   = NUM_PORTS,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PUSH_LAT = 2,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     enable,
  input  logic [NUM_IN-1:0]        in_push,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_pop,
  input  logic [NUM_PORTS-1:0]     out_pausa,
  output logic [NUM_PORTS-1:0]     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic                     active,
  output logic                     error
);

  // The counter register supplies the last cycle of push latency, so the delay line is one short.
  localparam int unsigned DlyStages = PUSH_LAT - 1;

  state_e                         state_q, state_d;
  logic [DlyStages-1:0][NUM_IN-1:0] dly_q;
  logic [NUM_IN-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IN-1:0]              last_pop_q;
  logic [1:0]                     rr_q, rr_d;
  logic                           pop_vld_q;
  logic [1:0]                     pop_idx_q;
  logic                           hold_vld_q;
  logic [DATA_W-1:0]              hold_q;
  logic                           error_q;

  logic [NUM_IN-1:0] inc, has_word, elig, gnt, want;
  logic              gnt_vld, ovf, illegal;

  assign inc = dly_q[DlyStages-1];

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) has_word[i] = (cnt_q[i] != '0);
  end

  assign elig = has_word & ~last_pop_q & {NUM_IN{~|out_pausa}};

  rr_pick4 u_pick (
    .req_i  (elig),
    .rr_i   (rr_q),
    .gnt_o  (gnt),
    .valid_o(gnt_vld)
  );

  // A grant to an empty input is suppressed and flagged rather than issued.
  assign want    = (state_q == StArb && enable && gnt_vld) ? gnt : '0;
  assign illegal = |(want & ~has_word);
  assign in_pop  = want & has_word;

  assign rr_d = (|in_pop) ? onehot_to_idx(in_pop) + 2'd1 : rr_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (inc[i] && !in_pop[i]) begin
        if (cnt_q[i] == CNT_W'(DEPTH)) ovf = 1'b1;
        else                           cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!inc[i] && in_pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StArb;
      StArb:   if (!enable) state_d = StDrain;
      // No pop is issued in the last ARB cycle, so only the held word can remain.
      StDrain: if (!pop_vld_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      dly_q      <= '0;
      cnt_q      <= '0;
      last_pop_q <= '0;
      rr_q       <= '0;
      pop_vld_q  <= 1'b0;
      pop_idx_q  <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q[0]   <= in_push;
      for (int s = 1; s < DlyStages; s++) dly_q[s] <= dly_q[s-1];
      cnt_q      <= cnt_d;
      last_pop_q <= in_pop;
      rr_q       <= rr_d;
      pop_vld_q  <= |in_pop;
      pop_idx_q  <= onehot_to_idx(in_pop);
      hold_vld_q <= pop_vld_q;
      if (pop_vld_q) hold_q <= in_data[pop_idx_q*DATA_W +: DATA_W];
      error_q    <= error_q | ovf | illegal;
    end
  end

  always_comb begin
    out_push = '0;
    if (hold_vld_q) out_push[hold_q[DEST_MSB:DEST_LSB]] = 1'b1;
  end

  assign out_data = hold_q;
  assign active   = (state_q == StArb);
  assign error    = error_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter with a behavioural model of the upstream input FIFOs.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  in_push = '0;
  logic [23:0] in_data = '0;
  logic [3:0]  in_pop;
  logic [3:0]  out_pausa = '0;
  logic [3:0]  out_push;
  logic [5:0]  out_data;
  logic        active;
  logic        error;

  logic [23:0] push_data = '0;
  logic [3:0]  pop_seen = '0;
  logic [3:0]  push_seen = '0;
  logic [23:0] push_dat_seen = '0;

  logic [5:0] fifo_q [4][$];
  logic [5:0] exp_q [$];
  int         pop_cyc [$];
  int         pop_idx [$];
  int         push_cyc [$];
  int         cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;

  fifo_rr_arbiter dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .enable   (enable),
    .in_push  (in_push),
    .in_data  (in_data),
    .in_pop   (in_pop),
    .out_pausa(out_pausa),
    .out_push (out_push),
    .out_data (out_data),
    .active   (active),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [5:0] mkw(input int i, input int j);
    return {2'((i + j + 1) % 4), 2'(i), 2'(j)};
  endfunction

  function automatic int n_pops_in(input int lo, input int hi);
    int n = 0;
    foreach (pop_cyc[j]) if (pop_cyc[j] >= lo && pop_cyc[j] <= hi) n++;
    return n;
  endfunction

  function automatic int n_push_in(input int lo, input int hi);
    int n = 0;
    foreach (push_cyc[j]) if (push_cyc[j] >= lo && push_cyc[j] <= hi) n++;
    return n;
  endfunction

  function automatic int first_pop_after(input int c);
    int r = -1;
    foreach (pop_cyc[j]) if (r < 0 && pop_cyc[j] > c) r = pop_cyc[j];
    return r;
  endfunction

  // Upstream FIFO model: registered data-out updated by the pop strobe seen before the edge.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 4; k++) fifo_q[k].delete();
      in_data <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop_seen[k]) begin
          check("pop_avail", 32'(fifo_q[k].size() != 0), 1);
          if (fifo_q[k].size() != 0) in_data[6*k +: 6] <= fifo_q[k].pop_front();
        end
        if (push_seen[k]) fifo_q[k].push_back(push_dat_seen[6*k +: 6]);
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    pop_seen      = in_pop;
    push_seen     = in_push;
    push_dat_seen = push_data;
    check("pop_1hot", 32'($onehot0(in_pop)), 1);
    check("push_1hot", 32'($onehot0(out_push)), 1);
    if (in_pop != '0) begin
      pop_cyc.push_back(cyc);
      pop_idx.push_back(idx_of(in_pop));
    end
    if (out_push != '0) begin
      push_cyc.push_back(cyc);
      check("push_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        check("out_push", 32'(out_push), 32'(4'b0001 << e[5:4]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    pop_idx.delete();
    push_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_L   = 1'b0;
    enable    = 1'b0;
    out_pausa = '0;
    in_push   = '0;
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic drive_push(input logic [3:0] mask, input logic [23:0] data);
    in_push   = mask;
    push_data = data;
    tick();
    in_push = '0;
  endtask

  task automatic load_two_each();
    for (int j = 0; j < 2; j++) begin
      drive_push(4'hF, {mkw(3, j), mkw(2, j), mkw(1, j), mkw(0, j)});
      for (int i = 0; i < 4; i++) exp_q.push_back(mkw(i, j));
    end
  endtask

  task automatic wait_pops(input int n);
    int b = 0;
    while (pop_idx.size() < n && b < 50) begin
      tick();
      b++;
    end
    check("pop_wait", 32'(pop_idx.size()), 32'(n));
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      tick();
      b++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (4) tick();
  endtask

  initial begin
    int t0, p0;
    tick();
    check("rst_pop", 32'(in_pop), 0);
    check("rst_push", 32'(out_push), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_active", 32'(active), 0);
    check("rst_error", 32'(error), 0);
    reset_L = 1'b1;
    tick();
    clear_logs();

    // Basic route, plus a second word on the same input that must skip a cycle.
    enable = 1'b1;
    tick();
    check("arb_active", 32'(active), 1);
    t0 = cyc;
    drive_push(4'h1, {18'h0, 6'b10_0101});
    exp_q.push_back(6'h25);
    drive_push(4'h1, {18'h0, 6'h0A});
    exp_q.push_back(6'h0A);
    wait_drain();
    check("basic_npop", 32'(pop_idx.size()), 2);
    if (pop_idx.size() == 2) begin
      check("basic_idx", 32'(pop_idx[0]), 0);
      check("basic_lat", 32'(pop_cyc[0] - t0), 2);
      check("basic_gap", 32'(pop_cyc[1] - pop_cyc[0]), 2);
    end
    check("basic_npush", 32'(push_cyc.size()), 2);
    if (push_cyc.size() == 2 && pop_cyc.size() == 2)
      check("basic_p2p", 32'(push_cyc[0] - pop_cyc[0]), 2);

    // Round-robin over four loaded inputs.
    do_reset();
    load_two_each();
    tick();
    enable = 1'b1;
    wait_drain();
    check("rr_npop", 32'(pop_idx.size()), 8);
    foreach (pop_idx[j]) begin
      check("rr_order", 32'(pop_idx[j]), 32'(j % 4));
      if (j > 0) check("rr_gap", 32'(pop_cyc[j] - pop_cyc[j-1]), 1);
    end
    check("rr_npush", 32'(push_cyc.size()), 8);
    foreach (push_cyc[j]) if (j > 0) check("rr_push_gap", 32'(push_cyc[j] - push_cyc[j-1]), 1);

    // Pausa stall mid-stream.
    do_reset();
    enable = 1'b1;
    tick();
    load_two_each();
    wait_pops(3);
    out_pausa = 4'b0010;
    p0 = cyc;
    tick();
    tick();
    tick();
    out_pausa = '0;
    wait_drain();
    check("pausa_nopop", 32'(n_pops_in(p0, p0 + 2)), 0);
    check("pausa_inflight", 32'(n_push_in(p0, p0 + 1)), 2);
    check("pausa_resume", 32'(first_pop_after(p0 + 2)), 32'(p0 + 3));
    check("pausa_npush", 32'(push_cyc.size()), 8);

    // Empty inputs, then overflow of input 3 while disabled.
    do_reset();
    enable = 1'b1;
    repeat (6) tick();
    check("empty_nopop", 32'(pop_idx.size()), 0);
    enable = 1'b0;
    repeat (3) tick();
    repeat (4) drive_push(4'h8, {6'h3F, 18'h0});
    repeat (3) tick();
    check("ovf_pre_err", 32'(error), 0);
    check("ovf_pre_cnt", 32'(dut.cnt_q[3]), 4);
    drive_push(4'h8, {6'h3F, 18'h0});
    repeat (3) tick();
    check("ovf_err", 32'(error), 1);
    check("ovf_cnt", 32'(dut.cnt_q[3]), 4);
    check("ovf_nopop", 32'(pop_idx.size()), 0);

    // Asynchronous reset with two words in flight.
    do_reset();
    check("rst_err_clear", 32'(error), 0);
    enable = 1'b1;
    tick();
    drive_push(4'h7, {6'h0, 6'h31, 6'h12, 6'h23});
    wait_pops(2);
    reset_L = 1'b0;
    #1;
    check("arst_push", 32'(out_push), 0);
    check("arst_pop", 32'(in_pop), 0);
    check("arst_active", 32'(active), 0);
    check("arst_cnt", 32'(dut.cnt_q), 0);
    tick();
    reset_L = 1'b1;
    repeat (6) tick();
    check("arst_nostale", 32'(push_cyc.size()), 0);
    check("arst_npop", 32'(pop_idx.size()), 2);

    // Disable mid-stream, drain, then resume.
    do_reset();
    enable = 1'b1;
    tick();
    load_two_each();
    wait_pops(3);
    enable = 1'b0;
    p0 = cyc;
    #1;
    check("dis_nopop", 32'(in_pop), 0);
    tick();
    check("dis_drain_state", 32'(dut.state_q), 2);
    check("dis_active", 32'(active), 0);
    tick();
    check("dis_idle_state", 32'(dut.state_q), 0);
    repeat (3) tick();
    check("dis_inflight", 32'(n_push_in(p0, p0 + 1)), 2);
    check("dis_nopops", 32'(n_pops_in(p0, p0 + 4)), 0);
    check("dis_held", 32'(exp_q.size()), 5);
    enable = 1'b1;
    wait_drain();
    check("dis_npop", 32'(pop_idx.size()), 8);
    foreach (pop_idx[j]) check("dis_order", 32'(pop_idx[j]), 32'(j % 4));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Sits directly downstream of four input 6-bit FIFOs and upstream of four output 6-bit FIFOs.
- Picks a non-empty input FIFO in round-robin order and pops one word from it.
- Routes the word to the output FIFO selected by data bits [5:4] and pushes it there.
- Stops popping while any output FIFO reports Pausa, so words already in flight always have room.

Parameters:
- NUM_IN, 4, number of input FIFOs; fixed at 4 in this revision.
- DEPTH, 4, entries per input FIFO; sets the occupancy counter range 0..DEPTH.
- PUSH_LAT, 2, cycles from an upstream push strobe until that word can be popped.
- CNT_W, 3, occupancy counter width; must be at least clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- reset_L  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable; 0 means no new pops are issued.
- in_push  in  4  copy of the push strobe into each input FIFO i.
- in_data  in  4x6  Fifo_Data_out of each input FIFO, flattened as [6*i+5:6*i].
- in_pop  out  4  pop strobe to each input FIFO; one-hot or zero.
- out_pausa  in  4  Pausa flag from each output FIFO.
- out_push  out  4  push strobe to each output FIFO; one-hot or zero.
- out_data  out  6  data word to all output FIFOs.
- active  out  1  1 while the FSM is in ARB.
- error  out  1  sticky error: occupancy overflow or illegal pop.

Behaviour:
- Reset (async, reset_L=0) clears everything: in_pop=0, out_push=0, out_data=0, active=0, error=0, all counters=0, rr pointer=0, FSM=IDLE.
- Occupancy tracking:
  - in_push[i] enters a PUSH_LAT-deep shift register; the delayed strobe increments cnt[i].
  - A pop issued to input i decrements cnt[i].
  - Both in the same cycle: cnt[i] unchanged.
  - Increment with cnt[i]=DEPTH: error<=1 and cnt saturates at DEPTH.
- Eligibility of input i in cycle T: cnt[i]>0, i was not granted in T-1, and no bit of out_pausa is set.
- FSM states:
  - IDLE: leaves to ARB when enable=1.
  - ARB: issues pops; leaves to DRAIN when enable=0.
  - DRAIN: no new pops; returns to IDLE once the pipeline is empty (at most 2 cycles).
  - active=1 only in ARB.
- Arbitration (ARB):
  - Search starts at index rr and goes upward with wrap 3->0.
  - The first eligible input k gets in_pop[k]=1 for exactly one cycle.
  - rr<=k+1 mod 4.
  - No eligible input: no pop, rr unchanged.
- Pipeline, fixed latency:
  - T: pop issued to input k.
  - T+1: in_data[k] is valid; captured into a holding register at the end of T+1.
  - T+2: out_push[d]=1 and out_data=held word, where d=held word[5:4].
  - Sustained throughput is 1 word/cycle; at most 2 words are in flight.
- Pausa:
  - Blocks new pops only.
  - Words already in flight still complete their push, even if Pausa targets their own destination.
  - Output FIFOs raise Pausa with at least 2 free entries, so this cannot overflow them.
- The block never issues a pop to an input with cnt=0; if its internal logic ever would, error<=1 and the pop is suppressed.
- Reset mid-operation:
  - In-flight words are discarded and all counters cleared.
  - The upstream FIFOs are reset by the same reset_L, so their contents are discarded too.
- error clears only on reset.

Decomposition:
- Shared package (e.g. fifo_pkg) holds:
  - DATA_W=6 and DEST_MSB=5 / DEST_LSB=4.
  - FSM state encodings IDLE=2'd0, ARB=2'd1, DRAIN=2'd2.
  - NUM_PORTS=4.
- One sub-module, rr_pick4: combinational priority search over a 4-bit eligible vector starting at rr; outputs a one-hot grant and a valid bit.
- The top module holds the counters, the push-delay shift registers, the FSM and the output pipeline.

Test Plan:
- Basic route: in_push[0] with in_data[0]=6'b10_0101, enable=1.
  -> in_pop[0] pulses PUSH_LAT cycles later.
  -> out_push[2]=1 with out_data=6'h25 two cycles after the pop.
- Round-robin: all 4 inputs loaded with 2 words each, enable=1.
  -> pop order is 0,1,2,3,0,1,2,3.
  -> no input granted in two consecutive cycles.
  -> 8 pushes total, one per cycle.
- Pausa stall: assert out_pausa[1] mid-stream.
  -> no in_pop in the next cycle.
  -> the ≤2 in-flight words still pushed.
  -> pops resume the cycle after Pausa drops.
- Empty and overflow: enable=1 with no in_push -> in_pop stays 0.
  -> then 5 pushes to input 3 with enable=0 -> error=1 and cnt[3]=4.
- Reset mid-operation: reset_L=0 for 1 cycle while 2 words are in flight.
  -> out_push=0, in_pop=0, active=0, cnt=0 immediately (asynchronous).
  -> no stale push after release.
- Disable mid-stream: enable=0 in ARB.
  -> DRAIN; remaining in-flight words pushed; IDLE within 2 cycles; active=0.
